// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - operand register file and command sequencer driving a 4-bit combinational ALU
// Optional zero_flag output is enabled by defining ALU_SEQUENCER_ZERO_FLAG_EN.
module alu_sequencer #(
    parameter int NUM_REGS      = 4,
    parameter int REG_ADDR_W    = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_src_a,
    input  logic [REG_ADDR_W-1:0] cmd_src_b,
    input  logic [REG_ADDR_W-1:0] cmd_dst,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [3:0]            wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic [3:0]            rd_data,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic [1:0]            alu_op,
    output logic                  alu_enable,
    input  logic [3:0]            alu_result,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            done_data
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
    ,
    output logic                  zero_flag
`endif
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      settle_cnt;
    logic [REG_ADDR_W-1:0] dst_q;
    logic [3:0]            regs [NUM_REGS];

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rd_data   = regs[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            dst_q      <= '0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_op     <= 2'd0;
            alu_enable <= 1'b0;
            done       <= 1'b0;
            done_data  <= 4'd0;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
            zero_flag  <= 1'b0;
`endif
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 4'd0;
            end
        end else begin
            // Host load first so a capture to the same register in this edge overrides it.
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_a      <= regs[cmd_src_a];
                        alu_b      <= regs[cmd_src_b];
                        alu_op     <= cmd_op;
                        alu_enable <= 1'b1;
                        dst_q      <= cmd_dst;
                        settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (settle_cnt == '0) begin
                        regs[dst_q] <= alu_result;
                        done_data   <= alu_result;
                        done        <= 1'b1;
                        alu_enable  <= 1'b0;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
                        zero_flag   <= (alu_result == 4'd0);
`endif
                        state       <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
